// File: rtl/plot_sink.sv
// plot_sink: receiving end of the pixel plot interface.
// Queues plot commands, turns (x, y) into linear framebuffer addresses,
// issues one registered write per cycle and provides a full-screen clear.
module plot_sink #(
    parameter int unsigned WIDTH      = 160,
    parameter int unsigned HEIGHT     = 120,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [7:0]        x,
    input  logic [6:0]        y,
    input  logic [2:0]        colour,
    input  logic              plot,
    output logic              ready,
    input  logic              clear,
    input  logic [2:0]        clear_colour,
    input  logic              mem_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic [7:0]        dropped
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PIXELS = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_cmd_t;

    // Linear address y*WIDTH + x; shift-add form for the 160-pixel screen.
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [7:0] px,
                                                     input logic [6:0] py);
        logic [ADDR_W-1:0] res;
        if (WIDTH == 160) begin
            res = (ADDR_W'(py) << 7) + (ADDR_W'(py) << 5) + ADDR_W'(px);
        end else begin
            res = ADDR_W'(py) * ADDR_W'(WIDTH) + ADDR_W'(px);
        end
        return res;
    endfunction

    plot_cmd_t         fifo_q [FIFO_DEPTH];
    plot_cmd_t         fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [0:0]        state_q, state_d;
    logic              clear_pending_q, clear_pending_d;
    logic [2:0]        clear_colour_q, clear_colour_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [2:0]        mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic [7:0]        dropped_q, dropped_d;

    logic              in_range;
    logic              ready_c;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    plot_cmd_t         head;
    plot_cmd_t         new_cmd;

    // Acceptance decode: ready, range check, push/pop strobes.
    always_comb begin
        in_range   = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
        fifo_empty = (count_q == '0);
        ready_c    = (state_q == S_RUN) && !clear_pending_q &&
                     (32'(count_q) < FIFO_DEPTH);
        push       = plot && ready_c && in_range;
        pop        = (state_q == S_RUN) && !fifo_empty && !mem_stall;
        head       = fifo_q[rd_ptr_q];
        new_cmd    = '{x: x, y: y, colour: colour};
    end

    // FIFO pointer, occupancy and storage update.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = new_cmd;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Saturating count of rejected plots (not ready or out of range).
    always_comb begin
        dropped_d = dropped_q;
        if (plot && !push && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // Next-state and write-port logic: drain in S_RUN, sweep in S_CLEAR.
    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        clear_colour_d  = clear_colour_q;
        sweep_d         = sweep_q;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        mem_wren_d      = 1'b0;

        unique case (state_q)
            S_RUN: begin
                if (clear && !clear_pending_q) begin
                    clear_pending_d = 1'b1;
                    clear_colour_d  = clear_colour;
                end
                if (pop) begin
                    mem_addr_d = pixel_addr(head.x, head.y);
                    mem_data_d = head.colour;
                    mem_wren_d = 1'b1;
                end
                // Queued plots drain first so the sweep overwrites them.
                if (clear_pending_q && fifo_empty) begin
                    state_d = S_CLEAR;
                    sweep_d = '0;
                end
            end
            S_CLEAR: begin
                if (!mem_stall) begin
                    mem_addr_d = sweep_q;
                    mem_data_d = clear_colour_q;
                    mem_wren_d = 1'b1;
                    if (sweep_q == LAST_ADDR) begin
                        state_d         = S_RUN;
                        clear_pending_d = 1'b0;
                        sweep_d         = '0;
                    end else begin
                        sweep_d = sweep_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            state_q         <= S_RUN;
            clear_pending_q <= 1'b0;
            clear_colour_q  <= '0;
            sweep_q         <= '0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            mem_wren_q      <= 1'b0;
            dropped_q       <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            clear_colour_q  <= clear_colour_d;
            sweep_q         <= sweep_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            mem_wren_q      <= mem_wren_d;
            dropped_q       <= dropped_d;
        end
    end

    // FIFO payload storage; validity is tracked by the pointers alone.
    always_ff @(posedge clock) begin
        fifo_q <= fifo_d;
    end

    assign ready    = ready_c;
    assign busy     = !fifo_empty || clear_pending_q || (state_q == S_CLEAR);
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign dropped  = dropped_q;

endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel plot interface that the drawing FSMs drive: x, y, colour and a plot strobe.
- Buffers accepted plot commands in a small FIFO.
- Converts each (x, y) to a linear framebuffer address (y*WIDTH + x) and issues one registered write per cycle to a single-port framebuffer memory.
- Provides a full-screen clear engine (screen wipe between frogger levels) and a saturating count of rejected plots for debug.

Parameters:
- WIDTH, 160, pixels per row; x range 0..WIDTH-1.
- HEIGHT, 120, rows; y range 0..HEIGHT-1.
- FIFO_DEPTH, 4, plot command FIFO entries (power of 2).
- ADDR_W, 15, framebuffer address width; WIDTH*HEIGHT-1 = 19199 must fit.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  synchronous, active-low reset.
- x  in  8  plot x coordinate.
- y  in  7  plot y coordinate.
- colour  in  3  plot colour {R,G,B}.
- plot  in  1  plot request strobe; one command per high cycle.
- ready  out  1  high when a plot in this cycle will be taken.
- clear  in  1  request a full-screen fill.
- clear_colour  in  3  fill colour, sampled in the cycle clear is accepted.
- mem_stall  in  1  framebuffer port unavailable this cycle.
- mem_addr  out  ADDR_W  framebuffer write address.
- mem_data  out  3  framebuffer write data.
- mem_wren  out  1  framebuffer write enable.
- busy  out  1  high when the FIFO is non-empty, a clear is pending, or the FSM is in S_CLEAR.
- dropped  out  8  saturating count of rejected plots.

Behaviour:
- Reset: applied on any posedge clock with resetn=0, including mid-clear.
  - FIFO emptied; state S_RUN; clear_pending=0.
  - mem_addr=0, mem_data=0, mem_wren=0, dropped=0, clear sweep counter=0.
  - ready=1 and busy=0 in the first cycle after reset.
- ready (combinational): ready = (state==S_RUN) && !clear_pending && (fifo_count < FIFO_DEPTH).
- Plot acceptance:
  - plot && ready with x<WIDTH and y<HEIGHT: push {x,y,colour}.
  - plot && ready with x or y out of range: no push; dropped += 1.
  - plot && !ready: ignored; dropped += 1.
  - dropped saturates at 255.
- FSM states:
  - S_RUN: drains the FIFO.
  - S_CLEAR: sweeps the whole framebuffer.
- S_RUN drain:
  - Each cycle with FIFO non-empty and mem_stall=0: pop the head.
  - Register mem_addr = y*WIDTH + x, computed as (y<<7)+(y<<5)+x for the default width; width ADDR_W, no overflow for in-range inputs.
  - Register mem_data = colour and mem_wren = 1.
  - Otherwise mem_wren=0; mem_addr and mem_data hold their last values.
- Latency: plot accepted at edge N into an empty FIFO with no stall gives mem_wren=1 in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: 1 write per cycle. Simultaneous push and pop is legal at any occupancy below full; the count is unchanged.
- Clear request:
  - clear=1 while in S_RUN and clear_pending=0: set clear_pending and latch clear_colour.
  - clear while already pending or in S_CLEAR: ignored.
  - Plot and clear in the same cycle: the plot is accepted, and it is written before the sweep starts, so the sweep overwrites it.
- Clear transition: in S_RUN with clear_pending=1 and FIFO empty, go to S_CLEAR with sweep counter=0.
- S_CLEAR sweep:
  - Each cycle with mem_stall=0: mem_addr=counter, mem_data=latched colour, mem_wren=1; counter += 1.
  - Each cycle with mem_stall=1: mem_wren=0; counter holds.
  - After writing address WIDTH*HEIGHT-1 (19199): clear clear_pending, return to S_RUN, ready=1 the following cycle.
- Stall: mem_stall never loses a command; FIFO contents are held.

Test Plan:
- Single plot: reset, then plot x=10, y=20, colour=5 for one cycle → 2 cycles later mem_wren=1 for exactly 1 cycle with mem_addr=3210, mem_data=5; busy falls afterwards; dropped=0.
- Range check: plot x=160, y=5, then x=3, y=120 → no mem_wren; dropped=2. Then x=159, y=119 → mem_addr=19199.
- Back-pressure:
  - Hold mem_stall=1 and plot 5 consecutive commands (x=0..4, y=0) → ready falls after the 4th; the 5th is dropped (dropped=1).
  - Release the stall → writes to addr 0,1,2,3 on consecutive cycles, in order.
- Clear:
  - Pulse clear with clear_colour=3 while 2 plots are queued → the 2 plot writes happen first.
  - Then 19200 consecutive writes with mem_data=3, addresses 0..19199.
  - ready is low throughout and returns high one cycle after address 19199.
  - A plot issued during the sweep increments dropped.
- Stall during clear: assert mem_stall for 10 cycles at address 500 → no writes and the counter holds; resume at 500; total writes=19200.
- Reset mid-clear: assert resetn=0 at sweep address 7000 → next cycle mem_wren=0, ready=1, busy=0, dropped=0. A new plot is then written with 2-cycle latency.
